// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer
// Read-side adapter for the dual-clock FIFO, r_clk domain. Drains the FIFO
// read port into a 2-entry prefetch buffer and presents the words as a
// valid/ready stream. The FIFO read latency is hidden, so the stream can
// sustain one word per cycle.
//
// Ports:
//   r_clk     read-domain clock
//   rst_n     asynchronous active-low reset
//   empty     FIFO empty flag
//   rdata     FIFO read data (valid RD_LATENCY cycles after rd_rq)
//   rd_rq     FIFO read request (combinational, low while in reset)
//   flush     synchronous discard of buffered and in-flight words
//   m_valid   stream word valid
//   m_ready   downstream accept
//   m_data    stream word (oldest buffered entry)
//   rd_count  saturating count of words delivered downstream
//   err_ovf   sticky flag: a capture arrived while the buffer was full
module fifo_rd_streamer #(
  parameter int WIDTH      = 4,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 r_clk,
  input  logic                 rst_n,
  input  logic                 empty,
  input  logic [WIDTH-1:0]     rdata,
  output logic                 rd_rq,
  input  logic                 flush,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic                 err_ovf
);

  localparam bit                   LAT_ONE = (RD_LATENCY == 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     buf_r [2];
  logic                 head_r;
  logic [1:0]           count_r;
  logic                 inflight_r;
  logic [CNT_WIDTH-1:0] rd_count_r;
  logic                 err_ovf_r;

  logic                 pop_s;
  logic                 rd_rq_s;
  logic                 capture_s;
  logic                 wr_idx_s;
  logic [2:0]           occ_s;

  // Pop, read issue and capture decisions for the current cycle.
  always_comb begin
    pop_s    = (count_r != 2'd0) && m_ready;
    occ_s    = {1'b0, count_r} + {2'b00, inflight_r};
    // (count + inflight - pop) < 2, rearranged to avoid an unsigned underflow.
    if (rst_n && !empty && !flush && (occ_s < (3'd2 + {2'b00, pop_s}))) begin
      rd_rq_s = 1'b1;
    end else begin
      rd_rq_s = 1'b0;
    end
    if (LAT_ONE) begin
      // A word landing in a flush cycle is dropped.
      capture_s = inflight_r && !flush;
    end else begin
      capture_s = rd_rq_s;
    end
    // Tail slot: head + count (mod 2). With a coincident pop at count=2 this
    // is the slot being vacated by the head, which is exactly the new tail.
    wr_idx_s = head_r ^ count_r[0];
  end

  // Prefetch buffer, in-flight tracking, delivered counter and overflow flag.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r[0]   <= '0;
      buf_r[1]   <= '0;
      head_r     <= 1'b0;
      count_r    <= 2'd0;
      inflight_r <= 1'b0;
      rd_count_r <= '0;
      err_ovf_r  <= 1'b0;
    end else begin
      inflight_r <= LAT_ONE ? rd_rq_s : 1'b0;
      if (pop_s && (rd_count_r != CNT_MAX)) begin
        rd_count_r <= rd_count_r + CNT_ONE;
      end
      if (flush) begin
        count_r <= 2'd0;
        head_r  <= 1'b0;
      end else begin
        case ({capture_s, pop_s})
          2'b10: begin
            if (count_r == 2'd2) begin
              err_ovf_r <= 1'b1;
            end else begin
              buf_r[wr_idx_s] <= rdata;
              count_r         <= count_r + 2'd1;
            end
          end
          2'b01: begin
            head_r  <= ~head_r;
            count_r <= count_r - 2'd1;
          end
          2'b11: begin
            buf_r[wr_idx_s] <= rdata;
            head_r          <= ~head_r;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign rd_rq    = rd_rq_s;
  assign m_valid  = (count_r != 2'd0);
  assign m_data   = buf_r[head_r];
  assign rd_count = rd_count_r;
  assign err_ovf  = err_ovf_r;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: runs an RD_LATENCY=0 instance (3-bit counter,
// to reach saturation) and an RD_LATENCY=1 instance (16-bit counter) side by
// side from one shared FIFO word store, each with its own FIFO read pointer.
// A queue-level reference model predicts every output each cycle.
module tb_fifo_rd_streamer;

  logic r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  logic        rst_n, flush, m_ready;
  logic        empty_s [2];
  logic [3:0]  rdata_s [2];
  logic        rq [2];
  logic        v [2];
  logic        err [2];
  logic [3:0]  d [2];
  logic [2:0]  rc0;
  logic [15:0] rc1;

  // Shared FIFO word store; each instance drains it through its own pointer.
  logic [3:0]  fmem [4096];
  logic [11:0] wp;
  logic [11:0] erp [2];
  logic [3:0]  rd1_reg;

  assign empty_s[0] = (erp[0] == wp);
  assign empty_s[1] = (erp[1] == wp);
  assign rdata_s[0] = fmem[erp[0]];
  assign rdata_s[1] = rd1_reg;

  fifo_rd_streamer #(.WIDTH(4), .RD_LATENCY(0), .CNT_WIDTH(3)) u_lat0 (
    .r_clk(r_clk), .rst_n(rst_n), .empty(empty_s[0]), .rdata(rdata_s[0]),
    .rd_rq(rq[0]), .flush(flush), .m_valid(v[0]), .m_ready(m_ready),
    .m_data(d[0]), .rd_count(rc0), .err_ovf(err[0]));

  fifo_rd_streamer #(.WIDTH(4), .RD_LATENCY(1), .CNT_WIDTH(16)) u_lat1 (
    .r_clk(r_clk), .rst_n(rst_n), .empty(empty_s[1]), .rdata(rdata_s[1]),
    .rd_rq(rq[1]), .flush(flush), .m_valid(v[1]), .m_ready(m_ready),
    .m_data(d[1]), .rd_count(rc1), .err_ovf(err[1]));

  // Reference model: buffer as an ordered list, plus one pending word.
  int          mcnt [2];
  logic [3:0]  mbuf [2][2];
  bit          mpend [2];
  logic [3:0]  mpw [2];
  logic [11:0] mrp [2];
  int          mrdc [2];
  bit          merr [2];
  int          lat [2]  = '{0, 1};
  int          cmax [2] = '{7, 65535};

  bit          e_pop [2], e_rq [2], e_cap [2], d_rq [2];
  logic [3:0]  e_capw [2];

  int nchecks = 0;
  int nerrs   = 0;

  typedef struct {
    bit mr; bit fl;
    bit rq1; bit v1; logic [3:0] d1;
    bit rq0; bit v0; logic [3:0] d0;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rc_of(input int i);
    return (i == 0) ? int'(rc0) : int'(rc1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; mpend[i] = 1'b0; mrdc[i] = 0; merr[i] = 1'b0;
    end
  endtask

  task automatic push(input logic [3:0] w);
    fmem[wp] = w;
    wp = wp + 12'd1;
  endtask

  // Predict this cycle's outputs from the model and compare against the DUTs.
  task automatic pre_edge();
    bit ev, pend_c;
    #4;
    for (int i = 0; i < 2; i++) begin
      ev       = (mcnt[i] > 0);
      e_pop[i] = ev && m_ready;
      pend_c   = (lat[i] == 1) && mpend[i];
      e_rq[i]  = rst_n && (mrp[i] != wp) && !flush &&
                 ((mcnt[i] + int'(pend_c) - int'(e_pop[i])) < 2);
      e_cap[i] = (lat[i] == 0) ? e_rq[i] : (mpend[i] && !flush && rst_n);
      e_capw[i] = (lat[i] == 0) ? fmem[mrp[i]] : mpw[i];
      chk($sformatf("m_valid[%0d]", i), int'(v[i]), int'(ev));
      if (ev) chk($sformatf("m_data[%0d]", i), int'(d[i]), int'(mbuf[i][0]));
      chk($sformatf("rd_rq[%0d]", i), int'(rq[i]), int'(e_rq[i]));
      chk($sformatf("rd_count[%0d]", i), rc_of(i), mrdc[i]);
      chk($sformatf("err_ovf[%0d]", i), int'(err[i]), int'(merr[i]));
      d_rq[i] = rq[i];
    end
  endtask

  // Advance the FIFO environment and the model across one clock edge.
  task automatic edge_upd();
    @(posedge r_clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (d_rq[i]) begin
        if (i == 1) rd1_reg = fmem[erp[1]];
        erp[i] = erp[i] + 12'd1;
      end
      if (rst_n) begin
        if (e_pop[i]) begin
          mbuf[i][0] = mbuf[i][1];
          mcnt[i]--;
          if (mrdc[i] < cmax[i]) mrdc[i]++;
        end
        if (flush) mcnt[i] = 0;
        else if (e_cap[i]) begin
          if (mcnt[i] == 2) merr[i] = 1'b1;
          else begin
            mbuf[i][mcnt[i]] = e_capw[i];
            mcnt[i]++;
          end
        end
        mpend[i] = (lat[i] == 1) && e_rq[i];
        mpw[i]   = fmem[mrp[i]];
        if (e_rq[i]) mrp[i] = mrp[i] + 12'd1;
      end
    end
    if (!rst_n) model_reset();
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      pre_edge();
      edge_upd();
    end
  endtask

  int pulses [2];

  initial begin
    //        mr    fl    rq1   v1    d1     rq0   v0    d0
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 4'd2};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd3};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd4};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 1'b1, 1'b1, 4'd5};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 4'd6};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 1'b1, 1'b1, 4'd7};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 4'd8};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 4'd0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0};

    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
    wp = 12'd0; erp[0] = 12'd0; erp[1] = 12'd0; rd1_reg = 4'd0;
    mrp[0] = 12'd0; mrp[1] = 12'd0;
    for (int i = 0; i < 4096; i++) fmem[i] = 4'd0;
    model_reset();

    // Reset state, then idle with the FIFO empty.
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("reset m_valid", int'(v[i]), 0);
      chk("reset m_data", int'(d[i]), 0);
      chk("reset rd_rq", int'(rq[i]), 0);
      chk("reset rd_count", rc_of(i), 0);
      chk("reset err_ovf", int'(err[i]), 0);
    end
    @(posedge r_clk); #1;
    step(2);
    rst_n = 1'b1; m_ready = 1'b1;
    step(4);

    // Streaming 1..8 with m_ready held high, table driven.
    for (int k = 1; k <= 8; k++) push(4'(k));
    for (int r = 0; r < 11; r++) begin
      m_ready = tbl[r].mr; flush = tbl[r].fl;
      pre_edge();
      chk($sformatf("tbl%0d rd_rq1", r), int'(rq[1]), int'(tbl[r].rq1));
      chk($sformatf("tbl%0d m_valid1", r), int'(v[1]), int'(tbl[r].v1));
      if (tbl[r].v1) chk($sformatf("tbl%0d m_data1", r), int'(d[1]), int'(tbl[r].d1));
      chk($sformatf("tbl%0d rd_rq0", r), int'(rq[0]), int'(tbl[r].rq0));
      chk($sformatf("tbl%0d m_valid0", r), int'(v[0]), int'(tbl[r].v0));
      if (tbl[r].v0) chk($sformatf("tbl%0d m_data0", r), int'(d[0]), int'(tbl[r].d0));
      edge_upd();
    end
    chk("stream rd_count1", int'(rc1), 8);
    chk("stream rd_count0 saturated", int'(rc0), 7);

    // Backpressure: 5 words, m_ready low -> exactly 2 reads, head held at 1.
    m_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push(4'(k));
    pulses[0] = 0; pulses[1] = 0;
    for (int c = 0; c < 5; c++) begin
      pre_edge();
      for (int i = 0; i < 2; i++) begin
        pulses[i] += int'(rq[i]);
        if (c >= 2) chk("bp head held", int'(d[i]), 1);
      end
      edge_upd();
    end
    chk("bp rd_rq pulses0", pulses[0], 2);
    chk("bp rd_rq pulses1", pulses[1], 2);
    m_ready = 1'b1;
    step(8);
    chk("bp rd_count1", int'(rc1), 13);

    // Alternating m_ready over 16 words.
    for (int k = 0; k < 16; k++) push(4'(k));
    for (int c = 0; c < 40; c++) begin
      m_ready = (c % 2 == 0);
      step(1);
    end
    chk("alt rd_count1", int'(rc1), 29);
    chk("alt err_ovf1", int'(err[1]), 0);

    // Flush with a full buffer, then flush mid-stream with a word in flight.
    m_ready = 1'b0;
    for (int k = 9; k <= 14; k++) push(4'(k));
    step(4);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    pre_edge();
    chk("flush m_valid0", int'(v[0]), 0);
    chk("flush m_valid1", int'(v[1]), 0);
    edge_upd();
    m_ready = 1'b1;
    step(8);
    for (int k = 1; k <= 6; k++) push(4'(k));
    step(3);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(8);

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 1) push(4'($urandom_range(0, 15)));
      step(1);
    end
    flush = 1'b0; m_ready = 1'b1;
    step(8);

    // Asynchronous reset asserted mid-stream, between clock edges.
    for (int k = 3; k <= 9; k++) push(4'(k));
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async m_valid", int'(v[i]), 0);
      chk("async m_data", int'(d[i]), 0);
      chk("async rd_rq", int'(rq[i]), 0);
      chk("async rd_count", rc_of(i), 0);
    end
    model_reset();
    pre_edge();
    edge_upd();
    step(1);
    rst_n = 1'b1;
    step(12);
    chk("final err_ovf0", int'(err[0]), 0);
    chk("final err_ovf1", int'(err[1]), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
